// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master controller
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        TURN,
        RECV,
        GAP
    } spi_state_e;

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - PISO command register, SIPO reply register, shared bit counter
module spi_master_shifter
    import spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  sample_en,
    input  logic                  miso,
    input  logic                  cnt_clr,
    output logic                  tx_msb,
    output logic [DATA_BITS-1:0]  rx_next,
    output logic [3:0]            cnt
);

    logic [FRAME_BITS-1:0] tx_q;
    logic [DATA_BITS-1:0]  rx_q;

    assign tx_msb  = tx_q[FRAME_BITS-1];
    // Includes the bit being sampled this edge so the final byte is usable immediately.
    assign rx_next = {rx_q[DATA_BITS-2:0], miso};

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
            cnt  <= '0;
        end else begin
            if (load)
                tx_q <= load_data;
            else if (shift_en)
                tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
            if (sample_en)
                rx_q <= rx_next;
            cnt <= cnt_clr ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI initiator FSM; SPI_MASTER_SVA_EN adds protocol assertions
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FRAME_BITS-1:0] req_data,
    output logic                  SS_n,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  busy,
    output logic                  done,
    output logic                  rsp_valid,
    output logic [DATA_BITS-1:0]  rsp_data
);

    localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
    localparam logic [3:0] TURN_LAST  = 4'(RD_LAT - 1);
    localparam logic [3:0] RECV_LAST  = 4'(DATA_BITS - 1);

    spi_state_e           state_q, state_d;
    logic [1:0]           cmd_q;
    logic                 rd_frame;
    logic                 ss_n_d, mosi_d, ready_d, busy_d, done_d, rsp_valid_d, rsp_load;
    logic                 load, shift_en, sample_en, cnt_clr, tx_msb;
    logic [DATA_BITS-1:0] rx_next;
    logic [3:0]           cnt;

    assign rd_frame = (cmd_q == CMD_RD_DATA);

    spi_master_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (req_data),
        .shift_en  (shift_en),
        .sample_en (sample_en),
        .miso      (MISO),
        .cnt_clr   (cnt_clr),
        .tx_msb    (tx_msb),
        .rx_next   (rx_next),
        .cnt       (cnt)
    );

    always_comb begin
        state_d   = state_q;
        mosi_d    = 1'b0;
        load      = 1'b0;
        shift_en  = 1'b0;
        sample_en = 1'b0;
        cnt_clr   = 1'b0;
        rsp_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = SEL;
                    load    = 1'b1;
                    cnt_clr = 1'b1;
                    mosi_d  = req_data[FRAME_BITS-1];
                end
            end
            SEL: begin
                state_d  = SHIFT;
                cnt_clr  = 1'b1;
                mosi_d   = tx_msb;
                shift_en = 1'b1;
            end
            SHIFT: begin
                if (cnt == SHIFT_LAST) begin
                    state_d = rd_frame ? TURN : GAP;
                    cnt_clr = 1'b1;
                end else begin
                    mosi_d   = tx_msb;
                    shift_en = 1'b1;
                end
            end
            TURN: begin
                if (cnt == TURN_LAST) begin
                    state_d = RECV;
                    cnt_clr = 1'b1;
                end
            end
            RECV: begin
                sample_en = 1'b1;
                if (cnt == RECV_LAST) begin
                    state_d  = GAP;
                    rsp_load = 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        ss_n_d      = (state_d == IDLE) || (state_d == GAP);
        ready_d     = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == GAP);
        rsp_valid_d = (state_d == GAP) && rd_frame;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_q     <= CMD_WR_ADDR;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            SS_n      <= ss_n_d;
            MOSI      <= mosi_d;
            req_ready <= ready_d;
            busy      <= busy_d;
            done      <= done_d;
            rsp_valid <= rsp_valid_d;
            if (load)
                cmd_q <= req_data[FRAME_BITS-1:FRAME_BITS-2];
            if (rsp_load)
                rsp_data <= rx_next;
        end
    end

`ifdef SPI_MASTER_SVA_EN
    localparam int WR_LOW = FRAME_BITS + 1;
    localparam int RD_LOW = FRAME_BITS + DATA_BITS + 1 + RD_LAT;

    a_wr_len: assert property (@(posedge clk) disable iff (rst)
        ($fell(SS_n) && !rd_frame) |-> (!SS_n) [*WR_LOW] ##1 SS_n);
    a_rd_len: assert property (@(posedge clk) disable iff (rst)
        ($fell(SS_n) && rd_frame) |-> (!SS_n) [*RD_LOW] ##1 SS_n);
    a_done_edge: assert property (@(posedge clk) disable iff (rst)
        done |-> (SS_n && !$past(SS_n) && !$past(done)));
    a_rsp_done: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> done);
    a_ready_idle: assert property (@(posedge clk) disable iff (rst) req_ready |-> !busy);
    a_mosi_quiet: assert property (@(posedge clk) disable iff (rst) SS_n |-> !MOSI);
    c_rsp: cover property (@(posedge clk) disable iff (rst) rsp_valid);
    c_wr_done: cover property (@(posedge clk) disable iff (rst) done && !rsp_valid);
`endif

endmodule
